// File: rtl/memblk_req_port.sv
`default_nettype none
// ============================================================================
// Module   : memblk_req_port
// Brief    : Single-lane load/store initiator for a stall-frozen memblk lane.
// Revision : 1.0 - initial release
// ============================================================================
module memblk_req_port #(
   parameter int LAT   = 48,
   parameter int DEPTH = 16,
   parameter int TAGW  = 4,
   parameter int AW    = 39,
   parameter int DW    = 533
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_write,
   input  logic [AW-1:0]   req_addr,
   input  logic [DW-1:0]   req_wdata,
   input  logic [TAGW-1:0] req_tag,
   output logic [AW-1:0]   rdaddr0,
   output logic            rden_in,
   output logic [AW-1:0]   wraddr0,
   output logic [DW-1:0]   wrdata,
   output logic            wren_in,
   input  logic [DW-1:0]   rddata,
   output logic            rsp_valid,
   output logic [TAGW-1:0] rsp_tag,
   output logic [DW-1:0]   rsp_data,
   output logic [5:0]      outst
);

   localparam logic [5:0] c_DEPTH = 6'(DEPTH);

   logic                       w_accept;
   logic                       w_load_acc;
   logic                       w_rsp_cap;
   logic [TAGW-1:0]            r_iss_tag;
   logic [LAT-1:0]             r_tq_v;
   logic [LAT-1:0][TAGW-1:0]   r_tq_tag;

   assign req_ready  = !rst && !stall && (req_write || (outst < c_DEPTH));
   assign w_accept   = req_valid && req_ready;
   assign w_load_acc = w_accept && !req_write;
   assign w_rsp_cap  = !stall && r_tq_v[LAT-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         rdaddr0   <= '0;
         rden_in   <= 1'b0;
         wraddr0   <= '0;
         wrdata    <= '0;
         wren_in   <= 1'b0;
         r_iss_tag <= '0;
         r_tq_v    <= '0;
         r_tq_tag  <= '0;
         rsp_valid <= 1'b0;
         rsp_tag   <= '0;
         rsp_data  <= '0;
         outst     <= '0;
      end else if (!stall) begin
         rden_in <= 1'b0;
         wren_in <= 1'b0;
         if (w_accept) begin
            if (req_write) begin
               wraddr0 <= req_addr;
               wrdata  <= req_wdata;
               wren_in <= 1'b1;
            end else begin
               rdaddr0   <= req_addr;
               rden_in   <= 1'b1;
               r_iss_tag <= req_tag;
            end
         end
         // memblk samples the issue register on this edge, so its tag enters slot 0 now
         r_tq_v    <= {r_tq_v[LAT-2:0], rden_in};
         r_tq_tag  <= {r_tq_tag[LAT-2:0], r_iss_tag};
         rsp_valid <= r_tq_v[LAT-1];
         if (r_tq_v[LAT-1]) begin
            rsp_tag  <= r_tq_tag[LAT-1];
            rsp_data <= rddata;
         end
         outst <= outst + 6'(w_load_acc) - 6'(w_rsp_cap);
      end else begin
         rsp_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_memblk_req_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_memblk_req_port
// Brief    : Directed bench for memblk_req_port with a behavioural memblk lane.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memblk_req_port;
   localparam int LAT = 48, DEPTH = 16, TAGW = 4, AW = 39, DW = 533;
   typedef logic [DW-1:0] dw_t;

   logic            clk = 1'b0;
   logic            rst, stall, req_valid, req_ready, req_write;
   logic [AW-1:0]   req_addr, rdaddr0, wraddr0;
   logic [DW-1:0]   req_wdata, wrdata, rddata, rsp_data;
   logic [TAGW-1:0] req_tag, rsp_tag;
   logic            rden_in, wren_in, rsp_valid;
   logic [5:0]      outst;

   int checks = 0, failures = 0, cyc = 0;

   memblk_req_port #(.LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst), .stall(stall), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
      .rdaddr0(rdaddr0), .rden_in(rden_in), .wraddr0(wraddr0), .wrdata(wrdata),
      .wren_in(wren_in), .rddata(rddata), .rsp_valid(rsp_valid), .rsp_tag(rsp_tag),
      .rsp_data(rsp_data), .outst(outst)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural lane: read pipe frozen by stall, unwritten lines return their address
   logic [LAT-1:0] m_v;
   logic [AW-1:0]  m_a [LAT];
   logic [527:0]   mem [256];
   logic [255:0]   m_wr;
   logic [7:0]     w_idx;
   initial begin
      m_v  = '0;
      m_wr = '0;
   end
   always @(posedge clk) begin
      if (!stall) begin
         for (int i = LAT - 1; i > 0; i--) begin
            m_v[i] <= m_v[i-1];
            m_a[i] <= m_a[i-1];
         end
         m_v[0] <= rden_in;
         m_a[0] <= rdaddr0;
         if (wren_in) begin
            mem[wraddr0[11:4]]  <= wrdata[527:0];
            m_wr[wraddr0[11:4]] <= 1'b1;
         end
      end
   end
   assign w_idx  = m_a[LAT-1][11:4];
   assign rddata = m_wr[w_idx] ? {5'b0, mem[w_idx]} : {{(DW-AW){1'b0}}, m_a[LAT-1]};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input dw_t obs, input dw_t exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_rsp(input int limit);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!rsp_valid && n < limit);
   endtask

   int  a;
   int  seen;
   dw_t pat;

   initial begin
      rst = 1'b1; stall = 1'b0; req_valid = 1'b0; req_write = 1'b0;
      req_addr = '0; req_wdata = '0; req_tag = '0;
      repeat (3) tick();
      chk("rst_ready", dw_t'(req_ready), dw_t'(0));
      chk("rst_rden", dw_t'(rden_in), dw_t'(0));
      chk("rst_wren", dw_t'(wren_in), dw_t'(0));
      chk("rst_rspv", dw_t'(rsp_valid), dw_t'(0));
      chk("rst_outst", dw_t'(outst), dw_t'(0));
      rst = 1'b0;
      #1;
      chk("idle_ready", dw_t'(req_ready), dw_t'(1));

      // 1) single load, unstalled
      req_valid = 1'b1; req_addr = 39'h0_0000_1235; req_tag = 4'd3;
      tick(); a = cyc; req_valid = 1'b0;
      chk("t1_rden", dw_t'(rden_in), dw_t'(1));
      chk("t1_rdaddr", dw_t'(rdaddr0), dw_t'(39'h1235));
      chk("t1_outst1", dw_t'(outst), dw_t'(1));
      tick();
      chk("t1_rden_off", dw_t'(rden_in), dw_t'(0));
      wait_rsp(200);
      chk("t1_rspv", dw_t'(rsp_valid), dw_t'(1));
      chk("t1_lat", dw_t'(cyc - a), dw_t'(49));
      chk("t1_tag", dw_t'(rsp_tag), dw_t'(3));
      chk("t1_data", rsp_data, dw_t'(39'h1235));
      chk("t1_outst0", dw_t'(outst), dw_t'(0));
      tick();
      chk("t1_rspv_off", dw_t'(rsp_valid), dw_t'(0));

      // 2) exclusive load with 5 stalled edges in flight
      req_valid = 1'b1; req_addr = 39'h20_0000_0560; req_tag = 4'd5;
      tick(); a = cyc; req_valid = 1'b0;
      while (cyc < a + 20) tick();
      stall = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 39'h77;
      #1;
      chk("t2_ready_stall", dw_t'(req_ready), dw_t'(0));
      repeat (5) tick();
      chk("t2_wren_hold", dw_t'(wren_in), dw_t'(0));
      chk("t2_wraddr_hold", dw_t'(wraddr0), dw_t'(0));
      chk("t2_rdaddr_hold", dw_t'(rdaddr0), dw_t'(39'h20_0000_0560));
      stall = 1'b0; req_valid = 1'b0; req_write = 1'b0;
      wait_rsp(200);
      chk("t2_rspv", dw_t'(rsp_valid), dw_t'(1));
      chk("t2_lat", dw_t'(cyc - a), dw_t'(54));
      chk("t2_tag", dw_t'(rsp_tag), dw_t'(5));
      chk("t2_data", rsp_data, dw_t'(39'h20_0000_0560));

      // 3) 17 back-to-back loads against a credit limit of 16
      tick();
      req_valid = 1'b1; req_write = 1'b0;
      for (int i = 0; i < 16; i++) begin
         req_tag = 4'(i); req_addr = 39'(i << 4);
         tick();
      end
      req_tag = 4'd9; req_addr = 39'h1000;
      #1;
      chk("t3_outst16", dw_t'(outst), dw_t'(16));
      chk("t3_ready_full", dw_t'(req_ready), dw_t'(0));
      wait_rsp(100);
      chk("t3_rspv0", dw_t'(rsp_valid), dw_t'(1));
      chk("t3_tag0", dw_t'(rsp_tag), dw_t'(0));
      chk("t3_outst15", dw_t'(outst), dw_t'(15));
      chk("t3_ready_free", dw_t'(req_ready), dw_t'(1));
      tick(); req_valid = 1'b0;
      chk("t3_rden17", dw_t'(rden_in), dw_t'(1));
      chk("t3_rdaddr17", dw_t'(rdaddr0), dw_t'(39'h1000));
      chk("t3_outst_same", dw_t'(outst), dw_t'(15));
      chk("t3_tag1", dw_t'(rsp_tag), dw_t'(1));
      for (int k = 2; k <= 16; k++) begin
         wait_rsp(100);
         chk("t3_rspv", dw_t'(rsp_valid), dw_t'(1));
         chk("t3_tag", dw_t'(rsp_tag), dw_t'((k < 16) ? k : 9));
         chk("t3_data", rsp_data, dw_t'((k < 16) ? (k << 4) : 32'h1000));
      end
      chk("t3_outst_end", dw_t'(outst), dw_t'(0));

      // 4) store then load of the same line
      pat = {5'h15, {66{8'hA5}}};
      req_valid = 1'b1; req_write = 1'b1; req_addr = 39'h40; req_wdata = pat;
      tick();
      req_write = 1'b0; req_tag = 4'd7;
      chk("t4_wren", dw_t'(wren_in), dw_t'(1));
      chk("t4_wraddr", dw_t'(wraddr0), dw_t'(39'h40));
      chk("t4_wrdata", wrdata, pat);
      chk("t4_rden_st", dw_t'(rden_in), dw_t'(0));
      chk("t4_outst_st", dw_t'(outst), dw_t'(0));
      tick(); a = cyc; req_valid = 1'b0;
      chk("t4_wren_off", dw_t'(wren_in), dw_t'(0));
      chk("t4_rden", dw_t'(rden_in), dw_t'(1));
      wait_rsp(200);
      chk("t4_lat", dw_t'(cyc - a), dw_t'(49));
      chk("t4_tag", dw_t'(rsp_tag), dw_t'(7));
      chk("t4_data", rsp_data, {5'b0, pat[527:0]});

      // 5) reset with 8 loads in flight, asserted together with stall
      tick();
      req_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         req_tag = 4'(i); req_addr = 39'(32'h100 + (i << 4));
         tick();
         if (i == 0) a = cyc;
      end
      req_valid = 1'b0;
      while (cyc < a + 20) tick();
      rst = 1'b1; stall = 1'b1;
      #1;
      chk("t5_ready_rst", dw_t'(req_ready), dw_t'(0));
      tick();
      rst = 1'b0; stall = 1'b0;
      chk("t5_outst", dw_t'(outst), dw_t'(0));
      chk("t5_rden", dw_t'(rden_in), dw_t'(0));
      chk("t5_rdaddr", dw_t'(rdaddr0), dw_t'(0));
      chk("t5_wraddr", dw_t'(wraddr0), dw_t'(0));
      chk("t5_wrdata", wrdata, dw_t'(0));
      chk("t5_rsp_tag", dw_t'(rsp_tag), dw_t'(0));
      chk("t5_rsp_data", rsp_data, dw_t'(0));
      seen = 0;
      repeat (100) begin
         tick();
         if (rsp_valid) seen++;
      end
      chk("t5_no_rsp", dw_t'(seen), dw_t'(0));
      chk("t5_outst_end", dw_t'(outst), dw_t'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
